// File: rtl/cpu_pkg.sv
// cpu_pkg
// Shared definitions for the CPU datapath blocks: data width, the MIPS
// load/store opcodes understood by the memory stage, the memory-access FSM
// state encoding and a request classifier.
// No ports (package).
package cpu_pkg;

  localparam int DATA_W = 32;

  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SW  = 6'b101011;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_RMW_RD = 3'd2,
    ST_WRITE  = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  // Which path a freshly accepted request takes through the FSM.
  typedef enum logic [1:0] {
    CLS_ERR  = 2'd0,
    CLS_LOAD = 2'd1,
    CLS_SW   = 2'd2,
    CLS_SUB  = 2'd3
  } req_class_t;

  // Misaligned halfword/word accesses and unknown opcodes all collapse
  // into CLS_ERR so the FSM only has to look at one value.
  function automatic req_class_t classify(input logic [5:0] op,
                                          input logic [1:0] lane);
    case (op)
      OP_LB, OP_LBU: classify = CLS_LOAD;
      OP_LH, OP_LHU: classify = lane[0] ? CLS_ERR : CLS_LOAD;
      OP_LW:         classify = (lane != 2'b00) ? CLS_ERR : CLS_LOAD;
      OP_SB:         classify = CLS_SUB;
      OP_SH:         classify = lane[0] ? CLS_ERR : CLS_SUB;
      OP_SW:         classify = (lane != 2'b00) ? CLS_ERR : CLS_SW;
      default:       classify = CLS_ERR;
    endcase
  endfunction

endpackage

// File: rtl/mau_lane_align.sv
// mau_lane_align
// Purely combinational byte-lane logic for little-endian sub-word access.
// Also used by the forwarding unit, so it carries no state.
// Ports:
//   op         - load/store opcode
//   lane       - byte address bits [1:0]
//   word       - full memory word read at the aligned address
//   wdata      - store data (sub-word data in the low bits)
//   load_data  - selected lane, sign- or zero-extended (word for lw)
//   store_word - word with the store lane merged in (wdata for sw)
module mau_lane_align
  import cpu_pkg::*;
(
  input  logic [5:0]        op,
  input  logic [1:0]        lane,
  input  logic [DATA_W-1:0] word,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] load_data,
  output logic [DATA_W-1:0] store_word
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane select, then extend according to the signedness of the load.
  always_comb begin
    case (lane)
      2'b00:   byte_sel = word[7:0];
      2'b01:   byte_sel = word[15:8];
      2'b10:   byte_sel = word[23:16];
      default: byte_sel = word[31:24];
    endcase
    half_sel = lane[1] ? word[31:16] : word[15:0];

    case (op)
      OP_LB:   load_data = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:  load_data = {24'h000000, byte_sel};
      OP_LH:   load_data = {{16{half_sel[15]}}, half_sel};
      OP_LHU:  load_data = {16'h0000, half_sel};
      default: load_data = word;
    endcase
  end

  // Replace only the addressed lane; other lanes keep the value read back
  // from memory so the word-wide write leaves them untouched.
  always_comb begin
    store_word = wdata;
    case (op)
      OP_SB: begin
        store_word = word;
        case (lane)
          2'b00:   store_word[7:0]   = wdata[7:0];
          2'b01:   store_word[15:8]  = wdata[7:0];
          2'b10:   store_word[23:16] = wdata[7:0];
          default: store_word[31:24] = wdata[7:0];
        endcase
      end
      OP_SH: begin
        store_word = word;
        if (lane[1]) store_word[31:16] = wdata[15:0];
        else         store_word[15:0]  = wdata[15:0];
      end
      default: store_word = wdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit
// MEM-stage initiator for the word-wide data memory. Latches a load/store
// request, runs sub-word stores as read-modify-write, extracts and extends
// sub-word loads and flags misaligned or unknown requests.
// Ports:
//   clk, rst   - clock, asynchronous active-high reset
//   req        - request strobe, sampled only while ready=1
//   op, addr   - opcode and byte address
//   wdata      - store data
//   ready      - high only in IDLE
//   ack, err   - one-cycle completion pulse and its error flag
//   rdata      - last load result
//   mem_addr   - word-aligned address of the latched request
//   mem_wdata  - word to write, mem_we - word write enable
//   mem_rdata  - combinational read of the word at mem_addr
module mem_access_unit
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic [5:0]        op,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              ready,
  output logic              ack,
  output logic              err,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_t            state;
  state_t            next_state;
  req_class_t        req_cls;
  logic [5:0]        op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] merge_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;
  logic [DATA_W-1:0] load_data;
  logic [DATA_W-1:0] store_word;

  assign req_cls = classify(op, addr[1:0]);

  // One lane aligner serves both LOAD (extract) and RMW_RD (merge); both
  // work on the latched request and the word currently read from memory.
  mau_lane_align u_align (
    .op         (op_q),
    .lane       (addr_q[1:0]),
    .word       (mem_rdata),
    .wdata      (wdata_q),
    .load_data  (load_data),
    .store_word (store_word)
  );

  // State register. The asynchronous reset leaves WRITE immediately, which
  // is what drops mem_we before the next edge can commit a partial write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (req) begin
          case (req_cls)
            CLS_LOAD: next_state = ST_LOAD;
            CLS_SW:   next_state = ST_WRITE;
            CLS_SUB:  next_state = ST_RMW_RD;
            default:  next_state = ST_DONE;
          endcase
        end
      end
      ST_LOAD:   next_state = ST_DONE;
      ST_RMW_RD: next_state = ST_WRITE;
      ST_WRITE:  next_state = ST_DONE;
      ST_DONE:   next_state = ST_IDLE;
      default:   next_state = ST_IDLE;
    endcase
  end

  // Outputs decoded purely from state so mem_we cannot glitch outside WRITE.
  always_comb begin
    ready  = 1'b0;
    ack    = 1'b0;
    err    = 1'b0;
    mem_we = 1'b0;
    case (state)
      ST_IDLE:  ready  = 1'b1;
      ST_WRITE: mem_we = 1'b1;
      ST_DONE: begin
        ack = 1'b1;
        err = err_q;
      end
      default: ;
    endcase
  end

  assign rdata     = rdata_q;
  assign mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
  assign mem_wdata = merge_q;

  // Request latch and datapath registers. rdata_q is only written in LOAD,
  // so stores and errors leave the previous load result visible.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      merge_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req) begin
            op_q    <= op;
            addr_q  <= addr;
            wdata_q <= wdata;
            err_q   <= (req_cls == CLS_ERR);
            if (req_cls == CLS_SW) merge_q <= wdata;
          end
        end
        ST_LOAD:   rdata_q <= load_data;
        ST_RMW_RD: merge_q <= store_word;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit
// Randomized scoreboard bench for mem_access_unit. The driver predicts each
// response from a word-array memory model and queues it; an independent
// monitor compares every ack and every write the DUT produces.
module tb_mem_access_unit;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic [5:0]  op = 6'd0;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic        ready, ack, err, mem_we;
  logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          accept;
    int          lat;
    int          writes;
    logic [31:0] waddr;
    logic [31:0] wword;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] mem     [0:63];
  logic [31:0] ref_mem [0:63];
  logic [31:0] model_rdata = 32'd0;
  int          n_checks = 0;
  int          n_fail = 0;
  int          cycle = 0;
  bit          mon_en = 1'b0;
  bit          init_mem = 1'b1;

  always #5 clk = ~clk;

  mem_access_unit #(.ADDR_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .op        (op),
    .addr      (addr),
    .wdata     (wdata),
    .ready     (ready),
    .ack       (ack),
    .err       (err),
    .rdata     (rdata),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_rdata (mem_rdata)
  );

  function automatic logic [31:0] init_word(input int i);
    if (i == 16) return 32'h8899AABB;
    return 32'h5A5AA5A5 ^ (32'(i) * 32'h01030507);
  endfunction

  // Simple word memory: combinational read, write on the edge with mem_we.
  assign mem_rdata = mem[mem_addr[7:2]];

  always @(posedge clk) begin
    cycle <= cycle + 1;
    if (init_mem) begin
      for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
    end else if (mem_we) begin
      mem[mem_addr[7:2]] <= mem_wdata;
    end
  end

  task automatic check_output(input string name, input logic [31:0] act,
                              input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp_v);
    end
  endtask

  task automatic report_fail(input string name);
    n_checks++;
    n_fail++;
    $display("[TB] FAIL %s: event did not occur as required", name);
  endtask

  // Reference model: the memory as a word array, sub-word access by
  // shift/mask arithmetic on the byte address.
  function automatic exp_t predict(input logic [5:0] o, input logic [31:0] a,
                                   input logic [31:0] d);
    exp_t        e;
    int          idx;
    int          sh;
    logic [31:0] w;
    logic [31:0] v;
    logic [31:0] mask;
    idx = int'(a[7:2]);
    sh = int'(a[1:0]) * 8;
    w = ref_mem[idx];
    e.err = 1'b0;
    e.lat = 1;
    e.writes = 0;
    e.accept = 0;
    e.waddr = a & 32'hFFFFFFFC;
    e.wword = 32'd0;
    case (o)
      OP_LB, OP_LBU: begin
        v = (w >> sh) & 32'hFF;
        if (o == OP_LB && v >= 32'd128) v = v | 32'hFFFFFF00;
        model_rdata = v;
        e.lat = 2;
      end
      OP_LH, OP_LHU: begin
        if (a % 2 != 0) e.err = 1'b1;
        else begin
          v = (w >> sh) & 32'hFFFF;
          if (o == OP_LH && v >= 32'd32768) v = v | 32'hFFFF0000;
          model_rdata = v;
          e.lat = 2;
        end
      end
      OP_LW: begin
        if (a % 4 != 0) e.err = 1'b1;
        else begin
          model_rdata = w;
          e.lat = 2;
        end
      end
      OP_SB: begin
        mask = 32'hFF << sh;
        w = (w & ~mask) | ((d & 32'hFF) << sh);
        e.lat = 3;
        e.writes = 1;
      end
      OP_SH: begin
        if (a % 2 != 0) e.err = 1'b1;
        else begin
          mask = 32'hFFFF << sh;
          w = (w & ~mask) | ((d & 32'hFFFF) << sh);
          e.lat = 3;
          e.writes = 1;
        end
      end
      OP_SW: begin
        if (a % 4 != 0) e.err = 1'b1;
        else begin
          w = d;
          e.lat = 2;
          e.writes = 1;
        end
      end
      default: e.err = 1'b1;
    endcase
    if (e.writes != 0) begin
      e.wword = w;
      ref_mem[idx] = w;
    end
    e.rdata = model_rdata;
    return e;
  endfunction

  // Offers one request as soon as the DUT is ready; while it is busy, junk
  // is placed on the request inputs, which must be ignored.
  task automatic apply_stimulus(input logic [5:0] o, input logic [31:0] a,
                                input logic [31:0] d);
    exp_t e;
    int   waited = 0;
    @(negedge clk);
    while (!ready && waited < 50) begin
      req = 1'($urandom_range(0, 1));
      op = 6'($urandom);
      addr = $urandom;
      wdata = $urandom;
      @(negedge clk);
      waited++;
    end
    if (!ready) begin
      report_fail("ready_timeout");
      req = 1'b0;
      return;
    end
    req = 1'b1;
    op = o;
    addr = a;
    wdata = d;
    e = predict(o, a, d);
    @(posedge clk);
    #1;
    e.accept = cycle - 1;
    sb_q.push_back(e);
    req = 1'b0;
  endtask

  task automatic drain();
    int waited = 0;
    while ((sb_q.size() != 0 || !ready) && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    if (sb_q.size() != 0) report_fail("drain_timeout");
  endtask

  // Monitor: compares acks and writes against the head of the scoreboard.
  initial begin
    exp_t e;
    int   we_cnt = 0;
    forever begin
      @(negedge clk);
      if (!mon_en || rst) begin
        we_cnt = 0;
        continue;
      end
      if (sb_q.size() != 0 && !ready)
        check_output("mem_addr_hold", mem_addr, sb_q[0].waddr);
      if (mem_we) begin
        we_cnt++;
        if (sb_q.size() == 0) report_fail("unexpected_we");
        else begin
          check_output("we_addr", mem_addr, sb_q[0].waddr);
          check_output("we_data", mem_wdata, sb_q[0].wword);
        end
      end
      if (ack) begin
        if (sb_q.size() == 0) report_fail("unexpected_ack");
        else begin
          e = sb_q.pop_front();
          check_output("ack_err", 32'(err), 32'(e.err));
          check_output("ack_rdata", rdata, e.rdata);
          check_output("ack_latency", 32'(cycle - e.accept), 32'(e.lat));
          check_output("we_count", 32'(we_cnt), 32'(e.writes));
        end
        we_cnt = 0;
      end
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [5:0]  ops [0:7];
    logic [5:0]  o;
    logic [31:0] a;
    exp_t        e;
    int          waited;
    ops[0] = OP_LB;  ops[1] = OP_LH;  ops[2] = OP_LW;  ops[3] = OP_LBU;
    ops[4] = OP_LHU; ops[5] = OP_SB;  ops[6] = OP_SH;  ops[7] = OP_SW;
    for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);

    repeat (3) @(posedge clk);
    @(negedge clk);
    init_mem = 1'b0;
    check_output("reset_ready", 32'(ready), 32'd1);
    check_output("reset_ack", 32'(ack), 32'd0);
    check_output("reset_err", 32'(err), 32'd0);
    check_output("reset_we", 32'(mem_we), 32'd0);
    check_output("reset_rdata", rdata, 32'd0);
    rst = 1'b0;
    mon_en = 1'b1;

    // Directed sequence on word 0x40 = 0x8899AABB.
    apply_stimulus(OP_LB,  32'h41, 32'h0);
    apply_stimulus(OP_LBU, 32'h43, 32'h0);
    apply_stimulus(OP_LH,  32'h42, 32'h0);
    apply_stimulus(OP_LHU, 32'h40, 32'h0);
    apply_stimulus(OP_LW,  32'h40, 32'h0);
    apply_stimulus(OP_SB,  32'h42, 32'h123456CC);
    apply_stimulus(OP_SH,  32'h40, 32'h0000BEEF);
    apply_stimulus(OP_LW,  32'h40, 32'h0);
    apply_stimulus(OP_SW,  32'h44, 32'hDEADBEEF);
    apply_stimulus(OP_LW,  32'h44, 32'h0);
    apply_stimulus(OP_LW,  32'h42, 32'h0);
    apply_stimulus(OP_SH,  32'h41, 32'h0);
    apply_stimulus(6'b000000, 32'h40, 32'h0);
    drain();
    check_output("word40_after_merge", mem[16], 32'h88CCBEEF);
    check_output("word44_after_sw", mem[17], 32'hDEADBEEF);

    // Random traffic, mostly aligned, with some bad opcodes.
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 9))
        8:       o = 6'b000000;
        9:       o = 6'($urandom);
        default: o = ops[$urandom_range(0, 7)];
      endcase
      a = 32'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0) begin
        if (o == OP_LH || o == OP_LHU || o == OP_SH) a = a & 32'hFFFFFFFE;
        if (o == OP_LW || o == OP_SW) a = a & 32'hFFFFFFFC;
      end
      apply_stimulus(o, a, $urandom);
    end
    drain();
    for (int i = 0; i < 64; i++) check_output("mem_word", mem[i], ref_mem[i]);

    // Reset while a byte store sits in WRITE: no write may land.
    mon_en = 1'b0;
    @(negedge clk);
    req = 1'b1;
    op = OP_SB;
    addr = 32'h40;
    wdata = 32'h000000EE;
    @(posedge clk);
    #1;
    req = 1'b0;
    waited = 0;
    while (!mem_we && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    if (!mem_we) report_fail("reach_write");
    else begin
      #1;
      rst = 1'b1;
      #1;
      check_output("abort_we", 32'(mem_we), 32'd0);
      check_output("abort_ready", 32'(ready), 32'd1);
      check_output("abort_ack", 32'(ack), 32'd0);
      check_output("abort_rdata", rdata, 32'd0);
    end
    model_rdata = 32'd0;
    @(posedge clk);
    #1;
    check_output("abort_mem_word", mem[16], ref_mem[16]);

    // The first edge after release must accept a request.
    @(negedge clk);
    rst = 1'b0;
    req = 1'b1;
    op = OP_LW;
    addr = 32'h40;
    wdata = 32'h0;
    e = predict(OP_LW, 32'h40, 32'h0);
    mon_en = 1'b1;
    @(posedge clk);
    #1;
    e.accept = cycle - 1;
    sb_q.push_back(e);
    req = 1'b0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage initiator for the word-wide data memory in the five-stage pipelined CPU.
- Accepts load/store requests from the pipeline and drives word-aligned memory address, write data and write enable.
- Performs sub-word stores (sb, sh) as read-modify-write over the word-only write port.
- Extracts and extends sub-word loads. Reports misalignment.
- Pipeline stalls while ready=0.

Parameters:
- ADDR_W, 32, width of byte address from pipeline and to memory.

Ports:
- clk  in  1  clock; all state changes on posedge.
- rst  in  1  asynchronous, active-high reset.
- req  in  1  pipeline request; sampled only when ready=1.
- op  in  6  MIPS opcode: lb 100000, lh 100001, lw 100011, lbu 100100, lhu 100101, sb 101000, sh 101001, sw 101011.
- addr  in  ADDR_W  byte address.
- wdata  in  32  store data; sub-word data is taken from the low bits.
- ready  out  1  1 only in IDLE.
- ack  out  1  one-cycle completion pulse.
- err  out  1  valid with ack; 1 = misaligned or unsupported op, no memory write performed.
- rdata  out  32  extended load result; valid with ack for a load without error.
- mem_addr  out  ADDR_W  {addr[ADDR_W-1:2],2'b00} of the latched request.
- mem_wdata  out  32  full word to write.
- mem_we  out  1  word write enable; memory writes on the clock edge where mem_we=1.
- mem_rdata  in  32  combinational read of the word at mem_addr.

Behaviour:
- Byte lanes are little-endian: addr[1:0]=00 selects bits 7:0, 01 selects 15:8, 10 selects 23:16, 11 selects 31:24. Halfword at addr[1]=0 is bits 15:0; at addr[1]=1 it is bits 31:16.
- States: IDLE, LOAD, RMW_RD, WRITE, DONE.
- IDLE: if req=1, latch op, addr, wdata and classify the request:
  - misaligned (lh/lhu/sh with addr[0]=1; lw/sw with addr[1:0]!=0) or op not in list -> DONE with err_q=1;
  - load -> LOAD;
  - sw -> WRITE, with merge register = wdata;
  - sb/sh -> RMW_RD.
- LOAD: capture mem_rdata, select lane, sign-extend (lb, lh) or zero-extend (lbu, lhu) into rdata -> DONE.
- RMW_RD: merge register = mem_rdata with the selected byte/half lane replaced by wdata[7:0] or wdata[15:0] -> WRITE.
- WRITE: mem_we=1, mem_wdata = merge register -> DONE.
- DONE: ack=1, err=err_q -> IDLE.
- Latency from the request-accept edge to the ack cycle:
  - error: 1 cycle;
  - load and sw: 2 cycles;
  - sb/sh: 3 cycles.
- Back-to-back operation: a new request is accepted in the IDLE cycle after DONE.
- mem_we is decoded from state and is never 1 outside WRITE.
- mem_addr is held constant from accept through DONE.
- rdata holds its last load value; it is unchanged by stores and errors.
- req while ready=0 is ignored; the pipeline must hold the request.
- Reset, immediate and asynchronous: state=IDLE, ack=0, err=0, mem_we=0, rdata=0, merge register=0, latched request=0, ready=1.
  - Reset during RMW_RD or WRITE aborts the operation; no partial write is allowed after reset is asserted.
- Reset release: the first request can be accepted on the first posedge with rst=0.

Decomposition:
- Shared package (cpu_pkg):
  - opcode constants OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW;
  - state encoding constants;
  - width constant for data (32).
- One sub-module, mau_lane_align: purely combinational load-extract/extend and store-merge from (op, addr[1:0], word, wdata). It is reused by the forwarding unit.

Test Plan:
- Memory word 0x40 = 0x8899AABB; lb addr 0x41 -> ack at +2 cycles, rdata=0xFFFFFFAA, err=0. lbu 0x43 -> rdata=0x00000088.
- lh 0x42 -> rdata=0xFFFF8899. lhu 0x40 -> 0x0000AABB. lw 0x40 -> 0x8899AABB.
- sb 0x42, wdata=0x123456CC, on 0x8899AABB -> mem_we=1 for exactly one cycle at +2, word becomes 0x88CCAABB, ack at +3. sh 0x40, wdata=0x0000BEEF -> word 0x88CCBEEF.
- sw 0x44 wdata=0xDEADBEEF -> mem_we at +1, ack at +2. Immediately issue lw 0x44 -> rdata=0xDEADBEEF.
- lw 0x42, sh 0x41, and op=000000 -> ack+err at +1, mem_we never 1, rdata unchanged.
- Start sb 0x40 and assert rst during WRITE before the posedge -> mem_we drops to 0 at once, memory word unchanged, ready=1, ack=0.
